// File: rtl/instr_mem_arbiter.sv
// rtl/instr_mem_arbiter.sv - fixed-priority core/loader arbiter for the shared instruction memory port
// Loader is forced through after MAX_WAIT consecutive denials; loader writes to the boot ROM get an error response.
module instr_mem_arbiter #(
    parameter int ADDR_WIDTH = 17,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    output logic [31:0]           core_rdata_o,
    input  logic                  dbg_req_i,
    input  logic                  dbg_we_i,
    input  logic [3:0]            dbg_be_i,
    input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
    input  logic [31:0]           dbg_wdata_i,
    output logic                  dbg_gnt_o,
    output logic                  dbg_rvalid_o,
    output logic [31:0]           dbg_rdata_o,
    output logic                  dbg_err_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    input  logic [31:0]           mem_rdata_i
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_CORE,
        RESP_DBG,
        RESP_DBG_ERR
    } resp_e;

    resp_e      resp_q, resp_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       dbg_win, core_win, boot_wr;

    always_comb begin
        dbg_win  = dbg_req_i && (!core_req_i || (wait_cnt_q >= MAX_WAIT_C));
        core_win = core_req_i && !dbg_win;
        boot_wr  = dbg_we_i && dbg_addr_i[ADDR_WIDTH-1];
    end

    // Grants are suppressed combinationally so nothing reaches memory while reset is held.
    assign core_gnt_o = core_win && !rst;
    assign dbg_gnt_o  = dbg_win && !rst;

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = core_addr_i;
        mem_wdata_o = dbg_wdata_i;
        mem_be_o    = 4'hF;
        if (dbg_gnt_o) begin
            mem_en_o   = !boot_wr;
            mem_we_o   = dbg_we_i && !boot_wr;
            mem_addr_o = dbg_addr_i;
            mem_be_o   = dbg_be_i;
        end else if (core_gnt_o) begin
            mem_en_o = 1'b1;
        end
    end

    always_comb begin
        resp_d = RESP_NONE;
        if (dbg_gnt_o) begin
            resp_d = boot_wr ? RESP_DBG_ERR : RESP_DBG;
        end else if (core_gnt_o) begin
            resp_d = RESP_CORE;
        end

        wait_cnt_d = 8'd0;
        if (dbg_req_i && !dbg_gnt_o && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else if (dbg_req_i && !dbg_gnt_o) begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q     <= RESP_NONE;
            wait_cnt_q <= 8'd0;
        end else begin
            resp_q     <= resp_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        core_rvalid_o = (resp_q == RESP_CORE);
        core_rdata_o  = (resp_q == RESP_CORE) ? mem_rdata_i : 32'd0;
        dbg_rvalid_o  = (resp_q == RESP_DBG) || (resp_q == RESP_DBG_ERR);
        dbg_err_o     = (resp_q == RESP_DBG_ERR);
        dbg_rdata_o   = (resp_q == RESP_DBG) ? mem_rdata_i : 32'd0;
    end

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// tb/tb_instr_mem_arbiter.sv - directed self-checking bench for instr_mem_arbiter
module tb_instr_mem_arbiter;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req_i;
    logic [AW-1:0] core_addr_i;
    logic          core_gnt_o, core_rvalid_o;
    logic [31:0]   core_rdata_o;
    logic          dbg_req_i, dbg_we_i;
    logic [3:0]    dbg_be_i;
    logic [AW-1:0] dbg_addr_i;
    logic [31:0]   dbg_wdata_i;
    logic          dbg_gnt_o, dbg_rvalid_o, dbg_err_o;
    logic [31:0]   dbg_rdata_o;
    logic          mem_en_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [3:0]    mem_be_o;
    logic [31:0]   mem_rdata_i;

    int n_checks = 0;
    int n_errors = 0;

    instr_mem_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .core_req_i(core_req_i), .core_addr_i(core_addr_i),
        .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_be_i(dbg_be_i),
        .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
        .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
        .dbg_err_o(dbg_err_o),
        .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // RAM words hold 0x1000_0000+index, ROM words 0xB000_0000+index; ROM ignores writes.
    logic [31:0] mem [0:511];
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]       = 32'h1000_0000 + 32'(i);
            mem[256 + i] = 32'hB000_0000 + 32'(i);
        end
        mem_rdata_i = 32'd0;
    end

    always @(posedge clk) begin
        if (mem_en_o) begin
            mem_rdata_i <= mem[{mem_addr_o[AW-1], mem_addr_o[9:2]}];
            if (mem_we_o && !mem_addr_o[AW-1]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_o[b]) mem[{1'b0, mem_addr_o[9:2]}][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_req_i = 1'b0;
        dbg_req_i  = 1'b0;
        dbg_we_i   = 1'b0;
        #1;
    endtask

    task automatic dbg_drive(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                             input logic [31:0] wdata);
        dbg_req_i   = 1'b1;
        dbg_we_i    = we;
        dbg_be_i    = be;
        dbg_addr_i  = addr;
        dbg_wdata_i = wdata;
        #1;
    endtask

    // Both ports requesting: dbg expected on cycle index first_dbg, then every 5th cycle.
    task automatic contend(input int n, input int first_dbg);
        core_req_i  = 1'b1;
        core_addr_i = '0;
        dbg_drive(1'b0, 4'hF, 17'h8, 32'd0);
        for (int k = 0; k < n; k++) begin
            check_eq($sformatf("cont_dbg_gnt_%0d", k), 32'(dbg_gnt_o),
                     32'((k >= first_dbg) && ((k - first_dbg) % 5 == 0)));
            check_eq($sformatf("cont_core_gnt_%0d", k), 32'(core_gnt_o),
                     32'(!((k >= first_dbg) && ((k - first_dbg) % 5 == 0))));
            cyc();
        end
    endtask

    initial begin
        rst = 1'b1;
        core_addr_i = '0;
        dbg_be_i = 4'hF;
        dbg_addr_i = '0;
        dbg_wdata_i = '0;
        dbg_we_i = 1'b0;
        core_req_i = 1'b1;
        dbg_req_i = 1'b1;
        cyc();
        cyc();
        check_eq("rst_core_gnt", 32'(core_gnt_o), 32'd0);
        check_eq("rst_dbg_gnt", 32'(dbg_gnt_o), 32'd0);
        check_eq("rst_mem_en", 32'(mem_en_o), 32'd0);
        check_eq("rst_core_rvalid", 32'(core_rvalid_o), 32'd0);
        check_eq("rst_dbg_rvalid", 32'(dbg_rvalid_o), 32'd0);
        check_eq("rst_dbg_rdata", dbg_rdata_o, 32'd0);
        idle();
        rst = 1'b0;
        cyc();

        // Core-only stream 0x0, 0x4, 0x8
        core_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                check_eq("core_rvalid", 32'(core_rvalid_o), 32'd1);
                check_eq("core_rdata", core_rdata_o, 32'h1000_0000 + 32'(i - 1));
                check_eq("core_dbg_rvalid", 32'(dbg_rvalid_o), 32'd0);
            end
            if (i == 3) begin
                core_req_i = 1'b0;
                #1;
            end else begin
                core_addr_i = 17'(4 * i);
                #1;
                check_eq("core_gnt", 32'(core_gnt_o), 32'd1);
                check_eq("core_mem_we", 32'(mem_we_o), 32'd0);
                check_eq("core_mem_be", 32'(mem_be_o), 32'hF);
                check_eq("core_dbg_gnt", 32'(dbg_gnt_o), 32'd0);
            end
            cyc();
        end
        check_eq("core_rvalid_end", 32'(core_rvalid_o), 32'd0);

        // Loader write then read of 0x100
        dbg_drive(1'b1, 4'hF, 17'h100, 32'hDEAD_BEEF);
        check_eq("wr_gnt", 32'(dbg_gnt_o), 32'd1);
        check_eq("wr_mem_we", 32'(mem_we_o), 32'd1);
        check_eq("wr_mem_addr", 32'(mem_addr_o), 32'h100);
        cyc();
        check_eq("wr_rvalid", 32'(dbg_rvalid_o), 32'd1);
        check_eq("wr_err", 32'(dbg_err_o), 32'd0);
        dbg_drive(1'b0, 4'hF, 17'h100, 32'd0);
        check_eq("rd_gnt", 32'(dbg_gnt_o), 32'd1);
        check_eq("rd_mem_we", 32'(mem_we_o), 32'd0);
        cyc();
        idle();
        check_eq("rd_rvalid", 32'(dbg_rvalid_o), 32'd1);
        check_eq("rd_rdata", dbg_rdata_o, 32'hDEAD_BEEF);
        check_eq("rd_core_rdata", core_rdata_o, 32'd0);

        // Byte-enable write into word 0x104 (initial 0x1000_0041)
        dbg_drive(1'b1, 4'b0010, 17'h104, 32'hAABB_CCDD);
        check_eq("be_mem_be", 32'(mem_be_o), 32'h2);
        cyc();
        dbg_drive(1'b0, 4'hF, 17'h104, 32'd0);
        cyc();
        idle();
        check_eq("be_rdata", dbg_rdata_o, 32'h1000_CC41);
        cyc();

        // Contention: dbg on 5th cycle, repeating
        contend(10, 4);
        idle();
        cyc();

        // Boot-region write is rejected, boot read passes through
        dbg_drive(1'b1, 4'hF, 17'h1_0020, 32'h1234_5678);
        check_eq("boot_wr_gnt", 32'(dbg_gnt_o), 32'd1);
        check_eq("boot_wr_mem_en", 32'(mem_en_o), 32'd0);
        check_eq("boot_wr_mem_we", 32'(mem_we_o), 32'd0);
        cyc();
        check_eq("boot_wr_rvalid", 32'(dbg_rvalid_o), 32'd1);
        check_eq("boot_wr_err", 32'(dbg_err_o), 32'd1);
        check_eq("boot_wr_rdata", dbg_rdata_o, 32'd0);
        dbg_drive(1'b0, 4'hF, 17'h1_0020, 32'd0);
        cyc();
        idle();
        check_eq("boot_rd_rvalid", 32'(dbg_rvalid_o), 32'd1);
        check_eq("boot_rd_err", 32'(dbg_err_o), 32'd0);
        check_eq("boot_rd_rdata", dbg_rdata_o, 32'hB000_0008);
        cyc();

        // Reset mid-operation after a core grant, with wait_cnt partly built up
        contend(2, 100);
        check_eq("mid_core_rvalid_pre", 32'(core_rvalid_o), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_core_rvalid_rst", 32'(core_rvalid_o), 32'd0);
        check_eq("mid_core_gnt_rst", 32'(core_gnt_o), 32'd0);
        check_eq("mid_mem_en_rst", 32'(mem_en_o), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        check_eq("mid_core_rvalid_rel", 32'(core_rvalid_o), 32'd0);
        check_eq("mid_dbg_rvalid_rel", 32'(dbg_rvalid_o), 32'd0);
        contend(5, 4);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_arbiter.md
# instr_mem_arbiter

Shares the single-ported instruction memory (SRAM plus boot ROM behind one enable/address port) between the core instruction-fetch port and the debug/AXI loader port. Core fetch has fixed priority. A bounded-wait counter keeps the loader from starving. Loader writes into the boot-ROM region are rejected with an error response. Sits between the core/debug interconnect and the instruction RAM wrapper; one memory access per cycle.

## Interface
- ADDR_WIDTH, 17, byte-address width of the instruction memory; MSB set selects the boot-ROM region.
- MAX_WAIT, 4, maximum consecutive cycles a pending loader request may be denied; legal range 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- core_req_i  in  1  core fetch request; read-only.
- core_addr_i  in  ADDR_WIDTH  core fetch address.
- core_gnt_o  out  1  core request accepted this cycle.
- core_rvalid_o  out  1  core read data valid.
- core_rdata_o  out  32  core read data.
- dbg_req_i  in  1  loader request.
- dbg_we_i  in  1  loader write enable.
- dbg_be_i  in  4  loader byte enables.
- dbg_addr_i  in  ADDR_WIDTH  loader address.
- dbg_wdata_i  in  32  loader write data.
- dbg_gnt_o  out  1  loader request accepted this cycle.
- dbg_rvalid_o  out  1  loader response valid (reads and writes).
- dbg_rdata_o  out  32  loader read data.
- dbg_err_o  out  1  loader response is an error; valid with dbg_rvalid_o.
- mem_en_o  out  1  memory access enable.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  memory byte enables.
- mem_rdata_i  in  32  memory read data, valid one cycle after mem_en_o.

## Operation
- Grant decision is combinational in the request cycle.
  - dbg wins when dbg_req_i=1 and either core_req_i=0 or wait_cnt ≥ MAX_WAIT.
  - Otherwise core wins if core_req_i=1.
  - At most one gnt per cycle.
- Granted request drives mem_* in the same cycle.
  - Core grant: mem_we_o=0, mem_be_o=4'hF.
  - No grant: mem_en_o=0, mem_we_o=0. mem_addr_o, mem_wdata_o and mem_be_o carry the core values (don't-care).
- Boot-region write: dbg_we_i=1 with dbg_addr_i[ADDR_WIDTH-1]=1.
  - Still granted, but mem_en_o=0 and mem_we_o=0.
  - Response next cycle with dbg_err_o=1 and dbg_rdata_o=0.
  - Boot-region reads are legal and pass through.
- wait_cnt: saturating counter, 8 bits.
  - Clears when dbg is granted or dbg_req_i=0.
  - Increments when dbg_req_i=1 and dbg is not granted.
- Response owner register resp_q ∈ {NONE, CORE, DBG, DBG_ERR}, loaded every cycle from the grant outcome.
  - resp_q=CORE: core_rvalid_o=1, core_rdata_o=mem_rdata_i.
  - resp_q=DBG: dbg_rvalid_o=1, dbg_rdata_o=mem_rdata_i, dbg_err_o=0. Write responses return mem_rdata_i as don't-care data.
  - resp_q=DBG_ERR: dbg_rvalid_o=1, dbg_rdata_o=0, dbg_err_o=1.
  - Non-owner rdata outputs are 0.
- Requesters hold req/addr/data stable until gnt.

## Timing
- Reset: resp_q=NONE, wait_cnt=0.
  - All rvalid, err and rdata outputs are 0 during reset.
  - mem_en_o and mem_we_o are 0 while rst=1, regardless of requests.
  - gnt outputs are 0 while rst=1.
- Latency:
  - gnt arrives in the same cycle as req when that requester wins.
  - rvalid arrives exactly 1 cycle after gnt.
- Throughput: one access per cycle, back-to-back grants allowed to either port.
- Simultaneous requests with wait_cnt < MAX_WAIT: core granted, wait_cnt+1.
- At wait_cnt = MAX_WAIT: dbg granted, core_gnt_o=0, wait_cnt→0.
- With both ports requesting continuously, dbg is granted once every MAX_WAIT+1 cycles.
- Reset asserted mid-access: the pending rvalid is dropped (resp_q→NONE asynchronously) and no response is issued after reset release.

## Test plan
- Core-only stream: addr 0x0, 0x4, 0x8 in consecutive cycles → core_gnt_o=1 each cycle; core_rvalid_o=1 from cycle 2 with RAM words in order; dbg outputs stay 0.
- Loader write then read, with core idle: write 0xDEADBEEF, be=4'hF, to 0x100 → mem_we_o=1 in the grant cycle, dbg_rvalid_o=1 with dbg_err_o=0 next cycle; a read of 0x100 then returns 0xDEADBEEF.
- Contention, MAX_WAIT=4, both requesting continuously: core granted 4 cycles, dbg granted on the 5th, pattern repeats; no cycle has both gnts.
- Boot-region write: dbg write to addr with MSB=1 → dbg_gnt_o=1, mem_en_o=0; next cycle dbg_rvalid_o=1, dbg_err_o=1, dbg_rdata_o=0. A boot-region read instead returns ROM data with err=0.
- Byte-enable write: dbg write be=4'b0010 → mem_be_o=4'b0010 in the grant cycle.
- Reset mid-operation: assert rst in the cycle after a core grant → core_rvalid_o=0 immediately and no rvalid after release; wait_cnt restarts from 0, so dbg is first forced through after MAX_WAIT denied cycles.
